alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Registered output stage directly downstream of the ALU. Captures y, c_out and v with the
//  opcode that produced them, derives n/z from y, and buffers results in a 2-entry skid FIFO
//  with valid/ready handshake so the consumer can stall without losing results.
//  Decouples the combinational ALU path from register-file writeback timing.
// PARAMETERS
//  W      3   operand/result width; must match the ALU's w (>=2)
//  DEPTH  2   FIFO entries; fixed at 2 (skid buffer), other values unsupported
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  in_valid    in   1  ALU result present this cycle
//  in_ready    out  1  stage can accept a result this cycle
//  in_opcode   in   W  opcode that produced in_y
//  in_y        in   W  ALU result y
//  in_c        in   1  ALU carry out
//  in_v        in   1  ALU overflow
//  flush       in   1  synchronous discard of all buffered entries
//  out_valid   out  1  head entry valid
//  out_ready   in   1  consumer takes head entry
//  out_opcode  out  W  head opcode
//  out_y       out  W  head result
//  out_c/out_v out  1  head carry / overflow
//  out_n/out_z out  1  head negative (y[W-1]) / zero (y==0)
//  occupancy   out  2  entries held (0..2)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (rst_n), clock is clk.
//  - Reset: count=0, out_valid=0, in_ready=1, occupancy=0; out_* data=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready (handshake on same-edge sampling).
//  - in_ready = (count<2), registered state only, no combinational path from out_ready.
//  - out_valid = (count!=0); out_* driven from head register, no comb path from in_*.
//  - Latency: push at edge t -> out_valid=1 with that data after edge t (visible cycle t+1).
//  - n,z computed from in_y at capture and stored; z=1 iff in_y=='0; n=in_y[W-1].
//  - count 0: push -> head<=in, count=1.
//  - count 1: push&pop -> head<=in, count=1; push only -> tail<=in, count=2; pop only -> 0.
//  - count 2: push impossible (in_ready=0); pop -> head<=tail, count=1.
//  - in_valid while in_ready=0: ignored; upstream holds data (no drop, no overwrite).
//  - flush: count<=0 next edge; a coincident push is discarded; a coincident pop still
//    counts as handshake-complete for the consumer. Data registers need not clear.
//  - Order strictly FIFO; occupancy == count at all times.
//  - rst_n asserted mid-transfer: entries dropped immediately, outputs to reset values.
// CONFIGURATION
//  ALU_STICKY_FLAGS_EN defined: adds ports sticky_v (out,1) and sticky_clr (in,1).
//   sticky_v<=1 on any pop whose out_v=1; sticky_clr clears it next edge; set wins over
//   clear in the same cycle; flush does not affect it; reset value 0.
//  Undefined: ports and register absent; all other behaviour identical.
// STRUCTURE
//  - alu_pkg: typedef struct packed alu_result_t {opcode, y, c, v, n, z}, parameterised by W
//    via localparam ALU_W; localparam OCC_W=2.
//  - Sub-module alu_flag_gen (comb: y -> n,z) instantiated on the capture path.
//  - Head/tail registers of alu_result_t; 2-bit count; no separate FSM beyond count.
// TESTING
//  1 reset: rst_n=0 mid-run with count=2 -> out_valid=0, in_ready=1, occupancy=0 at once.
//  2 single: push y=3'b101,c=1,v=0 -> next cycle out_valid=1,out_y=101,out_n=1,out_z=0.
//  3 stall: out_ready=0, push 3'b000 then 3'b011 -> occupancy=2, in_ready=0; 3rd in_valid
//    held; out_ready=1 -> pops 000 (z=1) then 011, then held third value, in order.
//  4 streaming: in_valid=out_ready=1 for 20 cycles, incrementing y -> occupancy stays 1,
//    one result per cycle, no gaps or repeats.
//  5 flush with count=2 and coincident push -> occupancy=0 next cycle, pushed value never out.
//  6 ALU_STICKY_FLAGS_EN: pop entry v=1 -> sticky_v=1; pop v=1 with sticky_clr=1 -> stays 1;
//    sticky_clr alone -> 0. Macro undefined: build compiles without those ports.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared types and constants for the ALU result stage.
//   ALU_W        : operand/result width (matches the ALU's w)
//   OCC_W        : width of the occupancy / count field
//   alu_result_t : one captured ALU result plus derived n/z flags
//   count_e      : entries held by the 2-entry skid buffer
package alu_pkg;

  localparam int unsigned ALU_W = 3;
  localparam int unsigned OCC_W = 2;

  typedef struct packed {
    logic [ALU_W-1:0] opcode;
    logic [ALU_W-1:0] y;
    logic             c;
    logic             v;
    logic             n;
    logic             z;
  } alu_result_t;

  typedef enum logic [OCC_W-1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } count_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and its consumer.
//   master : ALU/consumer side (drives in_*, flush, out_ready)
//   slave  : result stage side (drives in_ready, out_*, occupancy)
interface alu_result_stage_if
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_opcode;
  logic [W-1:0]     in_y;
  logic             in_c;
  logic             in_v;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_opcode;
  logic [W-1:0]     out_y;
  logic             out_c;
  logic             out_v;
  logic             out_n;
  logic             out_z;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_opcode, in_y, in_c, in_v, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_y, out_c, out_v, out_n, out_z, occupancy
  );

  modport slave (
    input  in_valid, in_opcode, in_y, in_c, in_v, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_y, out_c, out_v, out_n, out_z, occupancy
  );

endinterface

// File: rtl/alu_result_stage_flag_gen.sv
// alu_flag_gen: combinational negative/zero flag derivation from an ALU result.
//   y : result (in, W)
//   n : y[W-1] (out)
//   z : y == 0 (out)
module alu_flag_gen #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] y,
  output logic         n,
  output logic         z
);

  always_comb begin
    n = y[W-1];
    z = (y == '0);
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage after the ALU. Captures each result
// with its opcode and n/z flags into a 2-entry skid FIFO with valid/ready
// handshake on both sides.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : alu_result_stage_if.slave (in_* / out_* handshake, flush, occupancy)
// Optional build macro ALU_STICKY_FLAGS_EN adds:
//   sticky_clr (in)  : clears sticky_v on the next edge
//   sticky_v   (out) : set by any pop of an entry with v=1; set wins over clear
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned W     = ALU_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic                sticky_clr,
  output logic                sticky_v
`endif
);

  localparam logic [OCC_W-1:0] DEPTH_CNT = OCC_W'(DEPTH);

  count_e      count;
  alu_result_t head;
  alu_result_t tail;
  alu_result_t cap;
  logic        cap_n;
  logic        cap_z;
  logic        push;
  logic        pop;

  alu_flag_gen #(.W(W)) u_flag_gen (
    .y (bus.in_y),
    .n (cap_n),
    .z (cap_z)
  );

  always_comb begin
    cap.opcode = bus.in_opcode;
    cap.y      = bus.in_y;
    cap.c      = bus.in_c;
    cap.v      = bus.in_v;
    cap.n      = cap_n;
    cap.z      = cap_z;
  end

  // Both ready and valid come from the count register only, so neither side
  // sees a combinational path from the other.
  always_comb begin
    bus.in_ready   = (count < DEPTH_CNT);
    bus.out_valid  = (count != CNT_EMPTY);
    bus.occupancy  = count;
    bus.out_opcode = head.opcode;
    bus.out_y      = head.y;
    bus.out_c      = head.c;
    bus.out_v      = head.v;
    bus.out_n      = head.n;
    bus.out_z      = head.z;
  end

  always_comb begin
    push = bus.in_valid & bus.in_ready;
    pop  = bus.out_valid & bus.out_ready;
  end

  // The head register is always the oldest entry; tail only holds the
  // second entry while the consumer is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CNT_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (bus.flush) begin
      count <= CNT_EMPTY;
    end else begin
      case (count)
        CNT_EMPTY: begin
          if (push) begin
            head  <= cap;
            count <= CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (push && pop) begin
            head <= cap;
          end else if (push) begin
            tail  <= cap;
            count <= CNT_FULL;
          end else if (pop) begin
            count <= CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (pop) begin
            head  <= tail;
            count <= CNT_ONE;
          end
        end
        default: count <= CNT_EMPTY;
      endcase
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (pop && head.v) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end

  always_comb sticky_v = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_result_stage_if #(.W(ALU_W)) bus ();

`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_clr;
  logic sticky_v;
`endif

  alu_result_stage #(.W(ALU_W), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef ALU_STICKY_FLAGS_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_v   (sticky_v)
`endif
  );

  int checks = 0;
  int errors = 0;
  alu_result_t sb[$];

  function automatic alu_result_t mk(input logic [2:0] op, input logic [2:0] y,
                                     input logic c, input logic v);
    alu_result_t r;
    r.opcode = op;
    r.y      = y;
    r.c      = c;
    r.v      = v;
    r.n      = y[2];
    r.z      = (y == 3'b000);
    return r;
  endfunction

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_y      = '0;
    bus.in_c      = 1'b0;
    bus.in_v      = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
  endtask

  task automatic drive_in(input logic [2:0] op, input logic [2:0] y,
                          input logic c, input logic v);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_y      = y;
    bus.in_c      = c;
    bus.in_v      = v;
  endtask

  // Called at a falling edge with inputs already set: predicts the handshake,
  // scores any pop, advances one clock and checks status against the model.
  task automatic cycle(output logic accepted);
    logic        push;
    logic        pop;
    alu_result_t got;
    alu_result_t exp;
    push = bus.in_valid && bus.in_ready;
    pop  = bus.out_valid && bus.out_ready;
    accepted = push;
    if (pop) begin
      got.opcode = bus.out_opcode;
      got.y      = bus.out_y;
      got.c      = bus.out_c;
      got.v      = bus.out_v;
      got.n      = bus.out_n;
      got.z      = bus.out_z;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_underflow got=%h expected no valid entry", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL pop_data got=%h expected=%h", got, exp);
        end
      end
    end
    if (bus.flush) sb.delete();
    else if (push) sb.push_back(mk(bus.in_opcode, bus.in_y, bus.in_c, bus.in_v));
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.occupancy !== 2'(sb.size())) begin
      errors++;
      $display("FAIL occupancy got=%0d expected=%0d", bus.occupancy, sb.size());
    end
    checks++;
    if (bus.out_valid !== (sb.size() != 0)) begin
      errors++;
      $display("FAIL out_valid got=%b expected=%b", bus.out_valid, sb.size() != 0);
    end
    checks++;
    if (bus.in_ready !== (sb.size() < 2)) begin
      errors++;
      $display("FAIL in_ready got=%b expected=%b", bus.in_ready, sb.size() < 2);
    end
  endtask

  task automatic test_reset();
    logic acc;
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.occupancy} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_status got=%b%b%0d expected out_valid=0 in_ready=1 occ=0",
               bus.out_valid, bus.in_ready, bus.occupancy);
    end
    checks++;
    if ({bus.out_opcode, bus.out_y, bus.out_c, bus.out_v, bus.out_n, bus.out_z} !== '0) begin
      errors++;
      $display("FAIL reset_data got op=%b y=%b expected zeros", bus.out_opcode, bus.out_y);
    end
`ifdef ALU_STICKY_FLAGS_EN
    checks++;
    if (sticky_v !== 1'b0) begin
      errors++;
      $display("FAIL reset_sticky got=%b expected=0", sticky_v);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    // fill both entries, then reset mid-run
    drive_in(3'b001, 3'b110, 1'b1, 1'b1);
    cycle(acc);
    drive_in(3'b010, 3'b011, 1'b0, 1'b1);
    cycle(acc);
    drive_idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.occupancy} !== 4'b0100) begin
      errors++;
      $display("FAIL midrun_reset got out_valid=%b in_ready=%b occ=%0d expected 0 1 0",
               bus.out_valid, bus.in_ready, bus.occupancy);
    end
    checks++;
    if (bus.out_y !== 3'b000) begin
      errors++;
      $display("FAIL midrun_reset_y got=%b expected=000", bus.out_y);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic acc;
    drive_idle();
    drive_in(3'b010, 3'b101, 1'b1, 1'b0);
    cycle(acc);
    drive_idle();
    checks++;
    if ({bus.out_valid, bus.out_y, bus.out_c, bus.out_v, bus.out_n, bus.out_z} !== 8'b1_101_1_0_1_0) begin
      errors++;
      $display("FAIL single got v=%b y=%b c=%b v=%b n=%b z=%b expected 1 101 1 0 1 0",
               bus.out_valid, bus.out_y, bus.out_c, bus.out_v, bus.out_n, bus.out_z);
    end
    bus.out_ready = 1'b1;
    cycle(acc);
    drive_idle();
  endtask

  task automatic test_stall();
    logic acc;
    int   taken = 0;
    drive_idle();
    drive_in(3'b011, 3'b000, 1'b0, 1'b0);
    cycle(acc);
    drive_in(3'b100, 3'b011, 1'b1, 1'b0);
    cycle(acc);
    checks++;
    if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_full got occ=%0d in_ready=%b expected 2 0", bus.occupancy, bus.in_ready);
    end
    drive_in(3'b101, 3'b110, 1'b0, 1'b1);
    cycle(acc);
    if (acc) taken++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(acc);
      if (acc) begin
        taken++;
        bus.in_valid = 1'b0;
      end
    end
    checks++;
    if (taken != 1) begin
      errors++;
      $display("FAIL stall_third_accept got=%0d expected=1", taken);
    end
    drive_idle();
  endtask

  task automatic test_streaming();
    logic acc;
    drive_idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_in(3'(i + 1), 3'(i), 1'(i % 3 == 0), 1'(i % 5 == 0));
      cycle(acc);
      checks++;
      if (bus.occupancy !== 2'd1 || !acc) begin
        errors++;
        $display("FAIL stream_occ step=%0d got occ=%0d acc=%b expected 1 1", i, bus.occupancy, acc);
      end
    end
    bus.in_valid = 1'b0;
    cycle(acc);
    drive_idle();
  endtask

  task automatic test_flush();
    logic acc;
    drive_idle();
    drive_in(3'b001, 3'b111, 1'b1, 1'b0);
    cycle(acc);
    drive_in(3'b010, 3'b001, 1'b0, 1'b1);
    cycle(acc);
    drive_in(3'b110, 3'b100, 1'b1, 1'b1);
    bus.flush = 1'b1;
    cycle(acc);
    drive_idle();
    checks++;
    if (bus.occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_full got occ=%0d expected=0", bus.occupancy);
    end
    // one entry held, flush with a push that would have been accepted
    drive_in(3'b011, 3'b010, 1'b0, 1'b0);
    cycle(acc);
    drive_in(3'b111, 3'b101, 1'b1, 1'b0);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    cycle(acc);
    drive_idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_discard got out_valid=%b y=%b expected 0", bus.out_valid, bus.out_y);
      end
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic acc;
    drive_idle();
    for (int i = 0; i < 150; i++) begin
      if (!bus.in_valid || acc) begin
        drive_in(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
        bus.in_valid = 1'($urandom_range(0, 1));
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.flush     = ($urandom_range(0, 15) == 0);
      cycle(acc);
    end
    drive_idle();
    bus.out_ready = 1'b1;
    repeat (3) cycle(acc);
    drive_idle();
  endtask

`ifdef ALU_STICKY_FLAGS_EN
  task automatic test_sticky();
    logic acc;
    drive_idle();
    drive_in(3'b001, 3'b011, 1'b0, 1'b1);
    cycle(acc);
    drive_in(3'b010, 3'b100, 1'b0, 1'b1);
    cycle(acc);
    drive_idle();
    checks++;
    if (sticky_v !== 1'b0) begin
      errors++;
      $display("FAIL sticky_before_pop got=%b expected=0", sticky_v);
    end
    bus.out_ready = 1'b1;
    cycle(acc);
    checks++;
    if (sticky_v !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set got=%b expected=1", sticky_v);
    end
    sticky_clr = 1'b1;
    cycle(acc);
    checks++;
    if (sticky_v !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins got=%b expected=1", sticky_v);
    end
    drive_idle();
    bus.flush = 1'b1;
    cycle(acc);
    checks++;
    if (sticky_v !== 1'b1) begin
      errors++;
      $display("FAIL sticky_flush got=%b expected=1", sticky_v);
    end
    drive_idle();
    sticky_clr = 1'b1;
    cycle(acc);
    checks++;
    if (sticky_v !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear got=%b expected=0", sticky_v);
    end
    drive_idle();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_streaming();
    test_flush();
    test_random();
`ifdef ALU_STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
